// File: rtl/spi_pkg.sv
// Shared SPI definitions: register map, mode bit positions and endpoint state.
// Used by both the SPI controller and the SPI target.
package spi_pkg;

  localparam logic [2:0] SPI_ADDR_DATA   = 3'd0;
  localparam logic [2:0] SPI_ADDR_STATUS = 3'd2;
  localparam logic [2:0] SPI_ADDR_INT    = 3'd3;
  localparam logic [2:0] SPI_ADDR_MODE   = 3'd4;
  localparam logic [2:0] SPI_ADDR_FILL   = 3'd7;

  localparam int MODE_CPHA = 0;
  localparam int MODE_CPOL = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall pulses
// taken from the last synchronised stage against its previous value.
module spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_target.sv
// SPI target endpoint: 8-bit MSB-first frames in all four CPOL/CPHA modes,
// exposed through the same 3-bit register bus as the SPI controller.
module spi_target
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] FILL_DEFAULT = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_clk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic       miso_oe,
  output logic       interrupt,
  input  logic [2:0] reg_addr,
  input  logic [7:0] reg_data_in,
  output logic [7:0] reg_data_out,
  input  logic       reg_read,
  input  logic       reg_write
);

  logic w_sck_s, w_sck_rise, w_sck_fall;
  logic w_mosi_s, w_mosi_rise, w_mosi_fall;
  logic w_cs_s, w_cs_rise, w_cs_fall;
  logic w_unused;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .reset_n(reset_n), .i_async(spi_clk),
    .o_sync(w_sck_s), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .i_async(mosi),
    .o_sync(w_mosi_s), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .i_async(cs_n),
    .o_sync(w_cs_s), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

  assign w_unused = ^{w_sck_s, w_mosi_rise, w_mosi_fall, w_cs_s};

  spi_state_t r_state, w_state_next;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_sh, r_rx_data, r_tx_sh, r_tx_buf, r_fill;
  logic       r_rx_valid, r_overrun, r_tx_full, r_first, r_int_en, r_irq;
  logic [1:0] r_mode, r_mode_act, r_int_status;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_next = ACTIVE;
      ACTIVE:  if (w_cs_rise) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  logic       w_start, w_stop, w_act, w_cpol, w_cpha, w_lead, w_trail;
  logic       w_sample, w_shift_edge, w_done, w_load, w_shift, w_rd_data;
  logic [7:0] w_rx_next, w_load_val;
  logic [1:0] w_ist_clr;

  assign w_start      = (r_state == IDLE) && w_cs_fall;
  assign w_stop       = (r_state == ACTIVE) && w_cs_rise;
  assign w_act        = (r_state == ACTIVE) && !w_stop;
  assign w_cpol       = r_mode_act[MODE_CPOL];
  assign w_cpha       = r_mode_act[MODE_CPHA];
  assign w_lead       = w_cpol ? w_sck_fall : w_sck_rise;
  assign w_trail      = w_cpol ? w_sck_rise : w_sck_fall;
  assign w_sample     = w_act && (w_cpha ? w_trail : w_lead);
  assign w_shift_edge = w_act && (w_cpha ? w_lead : w_trail);
  assign w_rx_next    = {r_rx_sh[6:0], w_mosi_s};
  assign w_done       = w_sample && (r_bit_cnt == 3'd7);
  // CPHA=0 reloads on the trailing edge after the byte; CPHA=1 on the completing edge.
  assign w_load       = w_start || (w_cpha ? w_done : (w_shift_edge && r_bit_cnt == 3'd0));
  assign w_shift      = w_shift_edge && !w_load && !(w_cpha && r_first);
  assign w_load_val   = r_tx_full ? r_tx_buf : r_fill;
  assign w_rd_data    = reg_read && (reg_addr == SPI_ADDR_DATA);
  assign w_ist_clr    = (reg_write && reg_addr == SPI_ADDR_INT) ? reg_data_in[1:0] : 2'b00;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bit_cnt    <= '0;
      r_rx_sh      <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_overrun    <= 1'b0;
      r_tx_sh      <= '0;
      r_tx_buf     <= '0;
      r_tx_full    <= 1'b0;
      r_fill       <= FILL_DEFAULT;
      r_first      <= 1'b1;
      r_mode       <= '0;
      r_mode_act   <= '0;
      r_int_en     <= 1'b0;
      r_int_status <= '0;
      r_irq        <= 1'b0;
    end else begin
      if (r_state == IDLE) r_mode_act <= r_mode;

      if (w_start || w_stop) begin
        r_bit_cnt <= '0;
        r_first   <= 1'b1;
      end
      if (w_sample) begin
        r_rx_sh   <= w_rx_next;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_shift_edge && w_cpha) r_first <= 1'b0;
      if (w_done) r_first <= 1'b1;

      if (w_load) begin
        r_tx_sh   <= w_load_val;
        r_tx_full <= 1'b0;
      end else if (w_shift) begin
        r_tx_sh <= {r_tx_sh[6:0], 1'b0};
      end

      // Later assignments win: a read clears, a completing byte sets again.
      if (w_rd_data) r_rx_valid <= 1'b0;
      if (reg_write && reg_addr == SPI_ADDR_INT && reg_data_in[7]) r_overrun <= 1'b0;
      if (w_done) begin
        r_rx_data  <= w_rx_next;
        r_rx_valid <= 1'b1;
        if (r_rx_valid && !w_rd_data) r_overrun <= 1'b1;
      end
      r_int_status <= (r_int_status & ~w_ist_clr) | {w_stop, w_done};
      r_irq        <= |(r_int_status & {2{r_int_en}});

      if (reg_write) begin
        case (reg_addr)
          SPI_ADDR_DATA: begin
            r_tx_buf  <= reg_data_in;
            r_tx_full <= 1'b1;
          end
          SPI_ADDR_MODE: begin
            r_mode   <= reg_data_in[1:0];
            r_int_en <= reg_data_in[2];
          end
          SPI_ADDR_FILL: r_fill <= reg_data_in;
          default: ;
        endcase
      end
    end
  end

  assign miso      = (r_state == ACTIVE) ? r_tx_sh[7] : 1'b0;
  assign miso_oe   = (r_state == ACTIVE);
  assign interrupt = r_irq;

  always_comb begin
    reg_data_out = 'x;
    case (reg_addr)
      SPI_ADDR_DATA:   reg_data_out = r_rx_data;
      SPI_ADDR_STATUS: reg_data_out = {4'b0, r_overrun, ~r_tx_full, r_rx_valid, r_state == ACTIVE};
      SPI_ADDR_INT:    reg_data_out = {6'b0, r_int_status};
      SPI_ADDR_MODE:   reg_data_out = {5'b0, r_int_en, r_mode};
      SPI_ADDR_FILL:   reg_data_out = r_fill;
      default:         reg_data_out = 'x;
    endcase
  end

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: directed and randomised SPI frames against a
// register-level behavioural model of the target.
module tb_spi_target;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       reset_n, spi_clk, mosi, cs_n;
  logic       miso, miso_oe, interrupt;
  logic [2:0] reg_addr;
  logic [7:0] reg_data_in, reg_data_out;
  logic       reg_read, reg_write;

  always #5 clk = ~clk;

  spi_target #(.SYNC_STAGES(SYNC_STAGES), .FILL_DEFAULT(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .mosi(mosi), .cs_n(cs_n),
    .miso(miso), .miso_oe(miso_oe), .interrupt(interrupt),
    .reg_addr(reg_addr), .reg_data_in(reg_data_in), .reg_data_out(reg_data_out),
    .reg_read(reg_read), .reg_write(reg_write));

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [7:0] m_rx_data, m_tx_buf, m_fill;
  logic       m_rx_valid, m_overrun, m_tx_full, m_int_en;
  logic [1:0] m_ist, m_mode;

  logic [7:0] tb_mosi[4];
  logic [7:0] obs[4];
  logic [7:0] exp_b[4];
  logic [7:0] coin_data;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic m_reset();
    m_rx_data = 8'h00; m_rx_valid = 1'b0; m_overrun = 1'b0;
    m_tx_buf = 8'h00; m_tx_full = 1'b0; m_fill = 8'hFF;
    m_mode = 2'b00; m_int_en = 1'b0; m_ist = 2'b00;
  endtask

  task automatic m_load(output logic [7:0] v);
    v = m_tx_full ? m_tx_buf : m_fill;
    m_tx_full = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
    reg_addr = a; reg_read = 1'b1;
    #1 d = reg_data_out;
    @(negedge clk);
    reg_read = 1'b0;
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [7:0] d);
    reg_addr = a; reg_data_in = d; reg_write = 1'b1;
    @(negedge clk);
    reg_write = 1'b0;
    case (a)
      3'd0: begin m_tx_buf = d; m_tx_full = 1'b1; end
      3'd3: begin m_ist = m_ist & ~d[1:0]; if (d[7]) m_overrun = 1'b0; end
      3'd4: begin m_mode = d[1:0]; m_int_en = d[2]; end
      3'd7: m_fill = d;
      default: ;
    endcase
  endtask

  task automatic check_regs(input string tag);
    logic [7:0] d;
    reg_rd(3'd2, d); chk({tag, "_status"}, d, {4'b0, m_overrun, ~m_tx_full, m_rx_valid, 1'b0});
    reg_rd(3'd3, d); chk({tag, "_intst"}, d, {6'b0, m_ist});
    reg_rd(3'd4, d); chk({tag, "_mode"}, d, {5'b0, m_int_en, m_mode});
    reg_rd(3'd7, d); chk({tag, "_fill"}, d, m_fill);
    chk({tag, "_irq"}, {7'b0, interrupt}, {7'b0, |(m_ist & {2{m_int_en}})});
  endtask

  task automatic read_data(input string tag);
    logic [7:0] d;
    reg_rd(3'd0, d);
    chk({tag, "_rxdata"}, d, m_rx_data);
    m_rx_valid = 1'b0;
  endtask

  // Acts as the external controller; compares miso bytes against the model.
  task automatic spi_frame(input logic [1:0] md, input int nbits, input bit coincide,
                           input int reset_at);
    bit         aborted;
    logic       cpol, cpha;
    logic [7:0] e;
    int         full, k;
    aborted = 1'b0;
    cpol = md[1];
    cpha = md[0];
    spi_clk = cpol; cyc(6);
    cs_n = 1'b0; cyc(8);
    chk("miso_oe_on", {7'b0, miso_oe}, 8'h01);
    for (int b = 0; b < nbits; b++) begin
      if (b == reset_at) begin
        reset_n = 1'b0; cyc(2); reset_n = 1'b1; cyc(4);
        aborted = 1'b1;
        break;
      end
      if (!cpha) begin
        mosi = tb_mosi[b/8][7-(b%8)]; cyc(2);
        obs[b/8][7-(b%8)] = miso;
        spi_clk = ~cpol;
        if (coincide && b == nbits - 1) begin
          cyc(2);
          reg_addr = 3'd0; reg_read = 1'b1;
          #1 coin_data = reg_data_out;
          cyc(1); reg_read = 1'b0; cyc(1);
        end else begin
          cyc(4);
        end
        spi_clk = cpol; cyc(2);
      end else begin
        spi_clk = ~cpol; cyc(2);
        mosi = tb_mosi[b/8][7-(b%8)]; cyc(2);
        obs[b/8][7-(b%8)] = miso;
        spi_clk = cpol; cyc(4);
      end
    end
    if (aborted) begin
      m_reset();
    end else begin
      cyc(4);
      cs_n = 1'b1;
      k = 0;
      while (miso_oe && k < SYNC_STAGES + 1) begin
        @(negedge clk);
        k++;
      end
      chk("miso_oe_off", {7'b0, miso_oe}, 8'h00);
      cyc(4);
      full = nbits / 8;
      m_load(e); exp_b[0] = e;
      for (int i = 0; i < full; i++) begin
        if (coincide && i == full - 1) begin
          chk("coin_rdata", coin_data, m_rx_data);
          m_rx_valid = 1'b0;
        end
        if (m_rx_valid) m_overrun = 1'b1;
        m_rx_data = tb_mosi[i]; m_rx_valid = 1'b1; m_ist[0] = 1'b1;
        m_load(e); exp_b[i+1] = e;
      end
      m_ist[1] = 1'b1;
      for (int i = 0; i < full; i++) chk($sformatf("miso_byte%0d", i), obs[i], exp_b[i]);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    reset_n = 1'b0; spi_clk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
    reg_addr = 3'd0; reg_data_in = 8'h00; reg_read = 1'b0; reg_write = 1'b0;
    cyc(4);
    chk("rst_miso", {7'b0, miso}, 8'h00);
    chk("rst_miso_oe", {7'b0, miso_oe}, 8'h00);
    chk("rst_irq", {7'b0, interrupt}, 8'h00);
    reset_n = 1'b1; cyc(4);
    m_reset();
    check_regs("rst");
    read_data("rst");

    // Mode 0 single byte with queued TX 0xA5
    host_wr(3'd4, 8'h04);
    host_wr(3'd0, 8'hA5);
    tb_mosi[0] = 8'h3C;
    spi_frame(2'b00, 8, 1'b0, -1);
    chk("t1_miso_a5", obs[0], 8'hA5);
    check_regs("t1");
    read_data("t1");
    host_wr(3'd3, 8'h03);

    // Mode 3 two bytes, one queued TX byte then fill
    host_wr(3'd4, 8'h07);
    host_wr(3'd0, 8'h81);
    tb_mosi[0] = 8'($urandom); tb_mosi[1] = 8'($urandom);
    spi_frame(2'b11, 16, 1'b0, -1);
    chk("t2_fill", obs[1], 8'hFF);
    check_regs("t2");
    read_data("t2");
    host_wr(3'd3, 8'h03);

    // Mode 1 overrun, cleared through bit 7 of the interrupt register
    host_wr(3'd4, 8'h05);
    tb_mosi[0] = 8'($urandom); tb_mosi[1] = 8'($urandom);
    spi_frame(2'b01, 16, 1'b0, -1);
    check_regs("t3");
    host_wr(3'd3, 8'h80);
    check_regs("t3_clr");
    read_data("t3");
    host_wr(3'd3, 8'h03);

    // Mode 2 aborted after 5 bits
    host_wr(3'd4, 8'h06);
    tb_mosi[0] = 8'($urandom);
    spi_frame(2'b10, 5, 1'b0, -1);
    check_regs("t4");

    // Data read coinciding with second byte completion
    host_wr(3'd3, 8'h03);
    host_wr(3'd4, 8'h04);
    tb_mosi[0] = 8'($urandom); tb_mosi[1] = 8'($urandom);
    spi_frame(2'b00, 16, 1'b1, -1);
    check_regs("t5");
    read_data("t5");

    // Reset mid-frame with cs_n held low, then a clean frame
    tb_mosi[0] = 8'($urandom); tb_mosi[1] = 8'($urandom);
    spi_frame(2'b00, 16, 1'b0, 4);
    check_regs("t6_rst");
    read_data("t6_rst");
    cs_n = 1'b1; cyc(6);
    tb_mosi[0] = 8'($urandom);
    spi_frame(2'b00, 8, 1'b0, -1);
    check_regs("t6");
    read_data("t6");

    // Randomised frames
    for (int it = 0; it < 8; it++) begin
      logic [1:0] md;
      int         nb;
      md = 2'($urandom_range(0, 3));
      host_wr(3'd4, {5'b0, 1'($urandom_range(0, 1)), md});
      if ($urandom_range(0, 1) == 1) host_wr(3'd0, 8'($urandom));
      if ($urandom_range(0, 1) == 1) host_wr(3'd7, 8'($urandom));
      nb = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) tb_mosi[i] = 8'($urandom);
      spi_frame(md, nb * 8, 1'b0, -1);
      check_regs("rnd");
      if ($urandom_range(0, 1) == 1) read_data("rnd");
      host_wr(3'd3, {1'($urandom_range(0, 1)), 5'b0, 2'($urandom_range(0, 3))});
    end
    reg_rd(3'd2, d);
    chk("final_status", d, {4'b0, m_overrun, ~m_tx_full, m_rx_valid, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
